// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage and its neighbours: PC/jump and program-load inputs,
// plus the registered instruction stream toward decode.
interface instr_fetch_if #(
    parameter int unsigned PC_BITS    = 12,
    parameter int unsigned INSTR_BITS = 9
);
    logic [PC_BITS-1:0]    pc;
    logic                  jumpFlag;
    logic                  load_en;
    logic [PC_BITS-1:0]    load_addr;
    logic [INSTR_BITS-1:0] load_data;
    logic [INSTR_BITS-1:0] instr;
    logic [PC_BITS-1:0]    pc_out;
    logic                  instr_valid;
    logic                  done;
    logic [15:0]           instr_count;

    modport master (
        output pc, jumpFlag, load_en, load_addr, load_data,
        input  instr, pc_out, instr_valid, done, instr_count
    );

    modport slave (
        input  pc, jumpFlag, load_en, load_addr, load_data,
        output instr, pc_out, instr_valid, done, instr_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program load while held in start, registered fetch with
// one-bubble jump squash, sticky halt detection and a saturating retired-fetch counter.
module instr_fetch #(
    parameter int unsigned           PC_BITS    = 12,
    parameter int unsigned           INSTR_BITS = 9,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [INSTR_BITS-1:0] HALT_INSTR = '1
) (
    input logic          clock,
    input logic          start,
    instr_fetch_if.slave bus
);
    localparam int unsigned AddrW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

    state_e                state_q;
    logic [INSTR_BITS-1:0] instr_q;
    logic [PC_BITS-1:0]    pc_out_q;
    logic                  instr_valid_q;
    logic                  done_q;
    logic [15:0]           instr_count_q;

    logic [INSTR_BITS-1:0] mem [MEM_DEPTH];
    logic [INSTR_BITS-1:0] rd_data;
    logic                  fetch_in_range;
    logic                  load_in_range;
    logic                  halt_now;

    always_comb begin
        fetch_in_range = 32'(bus.pc) < MEM_DEPTH;
        load_in_range  = 32'(bus.load_addr) < MEM_DEPTH;
        rd_data        = '0;
        if (fetch_in_range) begin
            rd_data = mem[bus.pc[AddrW-1:0]];
        end
        halt_now = (state_q == StRun) && instr_valid_q && (instr_q == HALT_INSTR);
    end

    // Program memory is writable only inside the start window; no reset on contents.
    always_ff @(posedge clock) begin
        if (start && bus.load_en && load_in_range) begin
            mem[bus.load_addr[AddrW-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            state_q       <= StLoad;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            instr_count_q <= '0;
        end else begin
            unique case (state_q)
                StLoad, StRun: begin
                    if (state_q == StRun && instr_valid_q && instr_count_q != 16'hFFFF) begin
                        instr_count_q <= instr_count_q + 16'd1;
                    end
                    // A valid halt freezes instr/pc_out and ignores any jump at this edge.
                    if (halt_now) begin
                        state_q       <= StHalt;
                        done_q        <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end else begin
                        state_q       <= StRun;
                        instr_q       <= rd_data;
                        pc_out_q      <= bus.pc;
                        instr_valid_q <= !bus.jumpFlag;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.done        = done_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch, checked every cycle against a
// transaction-level model of the fetch stage.
module tb_instr_fetch;
    localparam int unsigned PcBits    = 12;
    localparam int unsigned InstrBits = 9;
    localparam int unsigned MemDepth  = 1024;
    localparam logic [8:0]  Halt      = 9'h1FF;

    logic clock = 1'b0;
    logic start;

    instr_fetch_if #(.PC_BITS(PcBits), .INSTR_BITS(InstrBits)) bus ();

    instr_fetch #(
        .PC_BITS   (PcBits),
        .INSTR_BITS(InstrBits),
        .MEM_DEPTH (MemDepth),
        .HALT_INSTR(Halt)
    ) dut (
        .clock(clock),
        .start(start),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: program image plus the output tuple decode should see.
    logic [8:0]  m_mem [MemDepth];
    logic [8:0]  m_instr;
    logic [11:0] m_pc;
    logic        m_valid;
    logic        m_done;
    logic        m_halted;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        if (start) begin
            if (bus.load_en && 32'(bus.load_addr) < MemDepth) begin
                m_mem[bus.load_addr[9:0]] = bus.load_data;
            end
            m_instr  = '0;
            m_pc     = '0;
            m_valid  = 1'b0;
            m_done   = 1'b0;
            m_halted = 1'b0;
            m_count  = 0;
        end else if (!m_halted) begin
            if (m_valid && m_count < 65535) m_count++;
            if (m_valid && m_instr == Halt) begin
                m_halted = 1'b1;
                m_done   = 1'b1;
                m_valid  = 1'b0;
            end else begin
                m_instr = (32'(bus.pc) < MemDepth) ? m_mem[bus.pc[9:0]] : 9'h000;
                m_pc    = bus.pc;
                m_valid = !bus.jumpFlag;
            end
        end
        @(posedge clock);
        #1;
        check("instr", 32'(bus.instr), 32'(m_instr));
        check("pc_out", 32'(bus.pc_out), 32'(m_pc));
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        check("done", 32'(bus.done), 32'(m_done));
        check("instr_count", 32'(bus.instr_count), m_count);
    endtask

    task automatic load_word(input logic [11:0] addr, input logic [8:0] data);
        start         = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        step();
        bus.load_en = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] addr, input logic jump);
        start        = 1'b0;
        bus.pc       = addr;
        bus.jumpFlag = jump;
        step();
        bus.jumpFlag = 1'b0;
    endtask

    initial begin
        start         = 1'b1;
        bus.pc        = '0;
        bus.jumpFlag  = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;

        // Reset window: outputs must read zero.
        for (int i = 0; i < 3; i++) step();
        check("reset_instr", 32'(bus.instr), 32'h0);
        check("reset_valid", 32'(bus.instr_valid), 32'h0);

        // Fill memory with random non-halt words, then place the directed program.
        for (int i = 0; i < int'(MemDepth); i++) begin
            load_word(12'(i), 9'($urandom_range(0, 510)));
        end
        load_word(12'd0, 9'h001);
        load_word(12'd1, 9'h002);
        load_word(12'd2, 9'h003);
        load_word(12'd3, Halt);
        load_word(12'd6, Halt);
        load_word(12'd1500, 9'h0F0);
        check("load_outputs_zero", 32'(bus.instr_count), 32'h0);

        // Straight-line program ending in a halt.
        fetch(12'd0, 1'b0);
        check("first_fetch", 32'(bus.instr), 32'h001);
        fetch(12'd1, 1'b0);
        fetch(12'd2, 1'b0);
        fetch(12'd3, 1'b0);
        check("halt_presented", 32'(bus.instr), 32'(Halt));
        fetch(12'd4, 1'b0);
        check("done_rises", 32'(bus.done), 32'h1);
        check("count_at_halt", 32'(bus.instr_count), 32'd4);
        fetch(12'd5, 1'b1);
        check("halt_frozen_pc", 32'(bus.pc_out), 32'd3);

        // Jump squash onto a wrong-path halt, then back-to-back jumps.
        start = 1'b1;
        step();
        fetch(12'd4, 1'b0);
        fetch(12'd5, 1'b0);
        fetch(12'd6, 1'b1);
        check("squash_bubble", 32'(bus.instr_valid), 32'h0);
        fetch(12'd40, 1'b0);
        check("target_valid", 32'(bus.instr_valid), 32'h1);
        fetch(12'd41, 1'b0);
        check("squashed_halt_no_done", 32'(bus.done), 32'h0);
        check("count_skips_bubble", 32'(bus.instr_count), 32'd3);
        fetch(12'd42, 1'b1);
        fetch(12'd43, 1'b1);
        check("b2b_second_bubble", 32'(bus.instr_valid), 32'h0);
        fetch(12'd50, 1'b0);
        check("b2b_recover", 32'(bus.instr_valid), 32'h1);

        // Restart mid-run with a concurrent load and jump.
        start = 1'b1;
        step();
        for (int i = 0; i < 8; i++) fetch(12'(100 + i), 1'b0);
        check("count_seven", 32'(bus.instr_count), 32'd7);
        bus.jumpFlag = 1'b1;
        load_word(12'd200, 9'h0AA);
        bus.jumpFlag = 1'b0;
        check("restart_count", 32'(bus.instr_count), 32'h0);
        check("restart_valid", 32'(bus.instr_valid), 32'h0);
        fetch(12'd0, 1'b0);
        check("mem_preserved", 32'(bus.instr), 32'h001);
        fetch(12'd200, 1'b0);
        check("load_with_start", 32'(bus.instr), 32'h0AA);

        // Out-of-range fetch and dropped out-of-range write.
        fetch(12'd1500, 1'b0);
        check("oor_instr", 32'(bus.instr), 32'h0);
        check("oor_valid", 32'(bus.instr_valid), 32'h1);
        fetch(12'd476, 1'b0);
        check("no_alias_476", 32'(bus.instr), 32'(m_mem[476]));

        // Random traffic with occasional restarts and fresh loads (some of them halts).
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.pc = 12'($urandom_range(0, 4095));
                load_word(12'($urandom_range(0, 1600)),
                          ($urandom_range(0, 3) == 0) ? Halt : 9'($urandom_range(0, 511)));
            end else begin
                bus.load_en   = ($urandom_range(0, 1) == 1);
                bus.load_addr = 12'($urandom_range(0, 1023));
                bus.load_data = Halt;
                fetch(12'($urandom_range(0, 1300)), ($urandom_range(0, 3) == 0));
                bus.load_en = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
